// File: rtl/score_display.sv
// score_display: double-dabble score to seven-segment driver; in clk/reset/start/bin_in/mode/lzb, out seg/bcd/busy/done/overflow
module score_display #(
  parameter int WIDTH = 7,
  parameter int DIGITS = 3,
  parameter int BLINK_DIV = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic [1:0]            mode,
  input  logic                  lzb,
  output logic [7*DIGITS-1:0]   seg,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [31:0] MAXVAL = 32'(10 ** DIGITS - 1);
  localparam logic [111:0] LUT = {42'h0, 7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t r_state;
  logic [WIDTH-1:0] r_sh;
  logic [4*DIGITS-1:0] r_wb, r_bcd, w_adj, w_next;
  logic [BW-1:0] r_bit;
  logic [CW-1:0] r_cnt;
  logic [7*DIGITS-1:0] w_seg;
  logic r_ovp, r_ovf, r_busy, r_done, r_phase, w_on;
  always_comb begin
    w_adj = r_wb;
    for (int k = 0; k < DIGITS; k++)
      w_adj[4*k+:4] = r_wb[4*k+:4] >= 4'd5 ? r_wb[4*k+:4] + 4'd3 : r_wb[4*k+:4];
  end
  assign w_next = {w_adj[4*DIGITS-2:0], r_sh[WIDTH-1]};
  always_comb begin
    logic nz;
    w_seg = '0;
    nz = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz = nz | (r_bcd[4*k+:4] != 4'd0) | (k == 0) | !lzb;
      w_seg[7*k+:7] = nz ? LUT[7*r_bcd[4*k+:4]+:7] : 7'h00;
    end
  end
  assign w_on = (mode == 2'b01) | (mode == 2'b10 & r_phase) | (mode == 2'b11 & (!r_ovf | r_phase));
  assign seg = w_on ? w_seg : '0;
  assign bcd = r_bcd;
  assign busy = r_busy;
  assign done = r_done;
  assign overflow = r_ovf;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sh <= '0;
      r_wb <= '0;
      r_bit <= '0;
      r_ovp <= 1'b0;
      r_ovf <= 1'b0;
      r_bcd <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_sh <= bin_in;
          r_wb <= '0;
          r_bit <= BW'(WIDTH);
          r_ovp <= 32'(bin_in) > MAXVAL;
          r_busy <= 1'b1;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_sh <= r_sh << 1;
          r_wb <= w_next;
          r_bit <= r_bit - BW'(1);
          // results are written on the final shift so they are visible during LATCH
          if (r_bit == BW'(1)) begin
            r_bcd <= r_ovp ? {DIGITS{4'h9}} : w_next;
            r_ovf <= r_ovp;
            r_done <= 1'b1;
            r_state <= LATCH;
          end
        end
        LATCH: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == CW'(BLINK_DIV - 1)) begin
      r_cnt <= '0;
      r_phase <= !r_phase;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed checks of score_display with default and two-digit/fast-blink instances
module tb_score_display;
  logic clk = 1'b0, reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, lzb0 = 1'b1, lzb1 = 1'b1;
  logic [6:0] bin0 = '0, bin1 = '0;
  logic [1:0] mode0 = 2'b00, mode1 = 2'b10;
  logic [20:0] seg0;
  logic [11:0] bcd0;
  logic [13:0] seg1;
  logic [7:0] bcd1;
  logic busy0, done0, ovf0, busy1, done1, ovf1;
  int n_cmp = 0, n_err = 0, tcnt = 0;
  int nb, nd, dc;
  always #5 clk = ~clk;
  score_display u0 (
    .clk(clk), .reset(reset), .start(start0), .bin_in(bin0), .mode(mode0), .lzb(lzb0),
    .seg(seg0), .bcd(bcd0), .busy(busy0), .done(done0), .overflow(ovf0)
  );
  score_display #(.WIDTH(7), .DIGITS(2), .BLINK_DIV(4)) u1 (
    .clk(clk), .reset(reset), .start(start1), .bin_in(bin1), .mode(mode1), .lzb(lzb1),
    .seg(seg1), .bcd(bcd1), .busy(busy1), .done(done1), .overflow(ovf1)
  );
  task automatic tick();
    @(posedge clk);
    tcnt = reset ? 0 : tcnt + 1;
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_bcd", bcd0, 12'h000);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_ovf", ovf0, 1'b0);
    chk("rst_seg_off", seg0, 21'h0);
    mode0 = 2'b01;
    #1;
    chk("rst_seg_solid", seg0, {7'h00, 7'h00, 7'h3F});
    bin0 = 7'd0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("z_c1_busy", busy0, 1'b1);
    chk("z_c1_done", done0, 1'b0);
    repeat (6) tick();
    chk("z_c7_done", done0, 1'b0);
    tick();
    chk("z_c8_done", done0, 1'b1);
    chk("z_c8_busy", busy0, 1'b1);
    chk("z_bcd", bcd0, 12'h000);
    chk("z_seg", seg0, {7'h00, 7'h00, 7'h3F});
    chk("z_ovf", ovf0, 1'b0);
    tick();
    chk("z_c9_busy", busy0, 1'b0);
    chk("z_c9_done", done0, 1'b0);
    bin0 = 7'd127;
    start0 = 1'b1;
    nb = 0;
    nd = 0;
    dc = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start0 = (c == 3);
      if (c == 3) bin0 = 7'd5;
      if (busy0) nb++;
      if (done0) begin
        nd++;
        dc = c;
      end
    end
    chk("m_busy_len", nb, 8);
    chk("m_done_cnt", nd, 1);
    chk("m_done_cyc", dc, 8);
    chk("m_bcd", bcd0, 12'h127);
    chk("m_seg", seg0, {7'h06, 7'h5B, 7'h07});
    chk("m_ovf", ovf0, 1'b0);
    mode0 = 2'b11;
    #1;
    chk("m_mode11_noovf", seg0, {7'h06, 7'h5B, 7'h07});
    mode0 = 2'b00;
    #1;
    chk("m_mode00", seg0, 21'h0);
    mode0 = 2'b01;
    bin0 = 7'd99;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ab_bcd", bcd0, 12'h000);
    chk("ab_busy", busy0, 1'b0);
    chk("ab_done", done0, 1'b0);
    chk("ab_ovf", ovf0, 1'b0);
    nd = 0;
    repeat (10) begin
      tick();
      if (done0) nd++;
    end
    chk("ab_nodone", nd, 0);
    bin0 = 7'd5;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (7) tick();
    chk("f_done", done0, 1'b1);
    chk("f_bcd", bcd0, 12'h005);
    chk("f_seg_lzb", seg0, {7'h00, 7'h00, 7'h6D});
    lzb0 = 1'b0;
    #1;
    chk("f_seg_nolzb", seg0, {7'h3F, 7'h3F, 7'h6D});
    lzb0 = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 0; t < 16; t++) begin
      chk("bl_mode10", seg1, ((tcnt / 4) % 2 == 0) ? 14'h003F : 14'h0);
      tick();
    end
    mode1 = 2'b00;
    repeat (4) begin
      #1;
      chk("bl_mode00", seg1, 14'h0);
      tick();
    end
    mode1 = 2'b11;
    bin1 = 7'd100;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (7) tick();
    chk("ov_done", done1, 1'b1);
    chk("ov_bcd", bcd1, 8'h99);
    chk("ov_flag", ovf1, 1'b1);
    for (int t = 0; t < 10; t++) begin
      chk("ov_blink", seg1, ((tcnt / 4) % 2 == 0) ? {7'h6F, 7'h6F} : 14'h0);
      tick();
    end
    bin1 = 7'd42;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (7) tick();
    chk("n_done", done1, 1'b1);
    chk("n_bcd", bcd1, 8'h42);
    chk("n_flag", ovf1, 1'b0);
    for (int t = 0; t < 8; t++) begin
      chk("n_steady", seg1, {7'h66, 7'h5B});
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/score_display.md
# score_display

Parametrised sequential score-to-seven-segment driver for the snakes game display path. It captures a binary score on a start pulse and converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per cycle. It then drives DIGITS seven-segment outputs with selectable off/solid/blink modes, leading-zero blanking, and saturating overflow indication. It sits between the score tracker and the ss* display ports, and supports wider scores and more digits than a fixed two-digit decode.

## Interface
- WIDTH, 7, width of the binary score input; legal range 1..20.
- DIGITS, 3, number of decimal digits driven; legal range 1..8.
- BLINK_DIV, 100, clk cycles per blink half-period; minimum 1.
- clk  input  1  system clock (hz100 domain).
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to capture bin_in and convert; ignored while busy.
- bin_in  input  WIDTH  unsigned binary score.
- mode  input  2  display mode: 00 off, 01 solid, 10 blink, 11 blink-on-overflow.
- lzb  input  1  leading-zero blanking enable.
- seg  output  7*DIGITS  digit k occupies seg[7k+6:7k], bit 0 = segment a … bit 6 = segment g, active-high; digit 0 is least significant.
- bcd  output  4*DIGITS  latched BCD result; digit k occupies bcd[4k+3:4k].
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when bcd, seg and overflow update.
- overflow  output  1  last captured value exceeded 10^DIGITS−1.

## Operation
- States: IDLE, SHIFT, LATCH.
- IDLE, start=1: capture bin_in into the shift register, clear working BCD, set busy, load bit counter = WIDTH. Compare bin_in against MAXVAL = 10^DIGITS−1 and hold the result as pending overflow. Go to SHIFT.
- SHIFT, each cycle: add 3 to every working BCD nibble ≥5, then shift {BCD, bin} left by 1 and decrement the counter. When the counter reaches 0, go to LATCH.
- LATCH, one cycle: write bcd. If pending overflow, bcd = all nibbles 9 and overflow=1; otherwise bcd = working BCD and overflow=0. Pulse done, clear busy, go to IDLE.
- start during SHIFT or LATCH: ignored, with no queuing.
- Segment encoding, digits 0–9 (hex): 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F. Blank = 00.
- Leading-zero blanking (lzb=1): a digit is blanked if it and every more-significant digit are 0. Digit 0 is never blanked, so a value of 0 shows "0".
- Blink phase: counter runs 0..BLINK_DIV−1. At terminal count, phase toggles and the counter resets. Full period = 2*BLINK_DIV cycles. The counter free-runs regardless of mode.
- Mode gating applies to the whole seg bus:
  - 00: all blank.
  - 01: always shown.
  - 10: shown when phase=1.
  - 11: shown when overflow=0; when overflow=1, shown only while phase=1.
- seg is combinational from the registered bcd, lzb, mode, phase and overflow. mode and lzb changes take effect the same cycle.

## Timing
- Reset values: seg=0 (follows bcd=0 and mode), bcd=0, busy=0, done=0, overflow=0, state IDLE, blink counter=0, phase=1.
- Latency: start sampled high in cycle 0 → busy=1 from cycle 1. done=1 and new bcd/seg/overflow are visible in cycle WIDTH+1. busy=0 from cycle WIDTH+2.
- Earliest accepted restart: cycle WIDTH+2.
- Reset asserted mid-conversion aborts the conversion: no done pulse, outputs return to reset values on the next edge.
- WIDTH=1: one SHIFT cycle, same rule.
- MAXVAL is computed as an elaboration-time constant at ≥27 bits to avoid truncation for DIGITS=8.
- The comparison uses the full bin_in width.

## Test plan
- Reset, then start with bin_in=0, lzb=1, mode=01, defaults → done in cycle 8. seg = {00, 00, 3F}, bcd=000, overflow=0.
- bin_in=127, WIDTH=7, DIGITS=3 → bcd=0x127, seg digits 2/1/0 = 06/5B/07. busy high for exactly 8 cycles.
- DIGITS=2, bin_in=100 → bcd=0x99, overflow=1. With mode=11, seg alternates between 6F6F and 0000 every BLINK_DIV cycles. Then bin_in=42 → overflow=0, seg steady.
- mode=10, BLINK_DIV=4 → seg toggles visible/blank every 4 cycles, starting visible after reset. mode=00 → seg=0 constantly.
- start pulsed again at cycle 3 of a conversion → ignored; only one done pulse; result matches the first capture.
- reset asserted at cycle 4 of a conversion of 99 → no done pulse; bcd=0, busy=0; a following start of 5 yields bcd=005.
